// File: rtl/pop_sequencer_n.sv
// N-channel gate sequencer for the pump/MW/probe/sample timing of the POP experiment.
// Per-channel start/stop edges and the period are double-buffered and committed only at cycle boundaries.
module pop_sequencer_n #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned N_CH       = 4,
  parameter int unsigned AW         = 6,
  parameter int unsigned DEF_PERIOD = 40000,
  parameter logic [N_CH*WIDTH-1:0] DEF_START = '0,
  parameter logic [N_CH*WIDTH-1:0] DEF_STOP  = '0
) (
  input  logic             clk_2M5,
  input  logic             reset,
  input  logic             enable,
  input  logic             oneshot,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [N_CH-1:0]  ch_out,
  output logic             cycle_start,
  output logic             busy,
  output logic [WIDTH-1:0] cycle_cnt,
  output logic [WIDTH-1:0] count
);

  // state | meaning
  // IDLE  | count held at 0, gates low, active registers follow shadow
  // RUN   | count sweeps 0..period-1, gates decoded from active registers
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [AW-1:0]    PERIOD_ADDR = AW'(2 * N_CH);
  localparam logic [WIDTH-1:0] ONE         = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_PERIOD  = WIDTH'(2);
  localparam logic [WIDTH-1:0] RST_PERIOD  = WIDTH'((DEF_PERIOD < 2) ? 2 : DEF_PERIOD);

  logic [0:0] state;
  logic       en_q;

  logic [WIDTH-1:0] sh_start   [N_CH];
  logic [WIDTH-1:0] sh_stop    [N_CH];
  logic [WIDTH-1:0] sh_period;
  logic [WIDTH-1:0] sh_start_d [N_CH];
  logic [WIDTH-1:0] sh_stop_d  [N_CH];
  logic [WIDTH-1:0] sh_period_d;
  logic [WIDTH-1:0] act_start  [N_CH];
  logic [WIDTH-1:0] act_stop   [N_CH];
  logic [WIDTH-1:0] act_period;

  logic en_rise;
  logic last_cnt;
  logic wrap;

  assign busy     = (state == ST_RUN);
  assign en_rise  = enable & ~en_q;
  assign last_cnt = (state == ST_RUN) && (count == act_period - ONE);
  assign wrap     = last_cnt && enable && !oneshot;

  // Shadow next-state: register file write decode
  always_comb begin
    sh_period_d = sh_period;
    for (int k = 0; k < N_CH; k++) begin
      sh_start_d[k] = sh_start[k];
      sh_stop_d[k]  = sh_stop[k];
      if (wr_en && (wr_addr == AW'(2 * k)))
        sh_start_d[k] = wr_data;
      if (wr_en && (wr_addr == AW'(2 * k + 1)))
        sh_stop_d[k] = wr_data;
    end
    if (wr_en && (wr_addr == PERIOD_ADDR))
      sh_period_d = (wr_data < MIN_PERIOD) ? MIN_PERIOD : wr_data;
  end

  always_ff @(posedge clk_2M5 or negedge reset) begin
    if (!reset) begin
      sh_period <= RST_PERIOD;
      for (int k = 0; k < N_CH; k++) begin
        sh_start[k] <= DEF_START[k*WIDTH +: WIDTH];
        sh_stop[k]  <= DEF_STOP[k*WIDTH +: WIDTH];
      end
    end else begin
      sh_period <= sh_period_d;
      for (int k = 0; k < N_CH; k++) begin
        sh_start[k] <= sh_start_d[k];
        sh_stop[k]  <= sh_stop_d[k];
      end
    end
  end

  // In IDLE the active set follows the shadow including this clock's write, so a
  // write coinciding with the enable rise is seen by the starting cycle. At a wrap
  // only the already-registered shadow commits; a same-clock write waits a cycle.
  always_ff @(posedge clk_2M5 or negedge reset) begin
    if (!reset) begin
      act_period <= RST_PERIOD;
      for (int k = 0; k < N_CH; k++) begin
        act_start[k] <= DEF_START[k*WIDTH +: WIDTH];
        act_stop[k]  <= DEF_STOP[k*WIDTH +: WIDTH];
      end
    end else if (state == ST_IDLE) begin
      act_period <= sh_period_d;
      for (int k = 0; k < N_CH; k++) begin
        act_start[k] <= sh_start_d[k];
        act_stop[k]  <= sh_stop_d[k];
      end
    end else if (wrap) begin
      act_period <= sh_period;
      for (int k = 0; k < N_CH; k++) begin
        act_start[k] <= sh_start[k];
        act_stop[k]  <= sh_stop[k];
      end
    end
  end

  always_ff @(posedge clk_2M5 or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      en_q        <= 1'b0;
      count       <= '0;
      cycle_start <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      en_q        <= enable;
      cycle_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          count <= '0;
          if (en_rise) begin
            state       <= ST_RUN;
            cycle_start <= 1'b1;
          end
        end
        ST_RUN: begin
          if (last_cnt) begin
            count     <= '0;
            cycle_cnt <= cycle_cnt + ONE;
            if (wrap)
              cycle_start <= 1'b1;
            else
              state <= ST_IDLE;
          end else begin
            count <= count + ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_2M5 or negedge reset) begin
    if (!reset) begin
      ch_out <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++)
        ch_out[k] <= (state == ST_RUN) && (count >= act_start[k]) && (count < act_stop[k]);
    end
  end

endmodule

// File: tb/tb_pop_sequencer_n.sv
// Bench for pop_sequencer_n: lockstep reference model plus table-driven single-cycle
// vectors and hand sequences for commit timing, enable drop, oneshot and reset.
module tb_pop_sequencer_n;
  localparam int WIDTH = 16;
  localparam int N_CH  = 4;
  localparam int AW    = 6;
  localparam int PADDR = 2 * N_CH;

  logic             clk_2M5 = 1'b0;
  logic             reset   = 1'b0;
  logic             enable  = 1'b0;
  logic             oneshot = 1'b0;
  logic             wr_en   = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic [N_CH-1:0]  ch_out;
  logic             cycle_start;
  logic             busy;
  logic [WIDTH-1:0] cycle_cnt;
  logic [WIDTH-1:0] count;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  pop_sequencer_n #(.WIDTH(WIDTH), .N_CH(N_CH), .AW(AW)) dut (
    .clk_2M5(clk_2M5), .reset(reset), .enable(enable), .oneshot(oneshot),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ch_out(ch_out),
    .cycle_start(cycle_start), .busy(busy), .cycle_cnt(cycle_cnt), .count(count)
  );

  always #5 clk_2M5 = ~clk_2M5;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: where the cycle stands (position, config in force, pending config)
  int m_period, m_sh_period;
  int m_start[N_CH], m_stop[N_CH], m_sh_start[N_CH], m_sh_stop[N_CH];
  bit m_run, m_cs, m_en_prev;
  int m_pos, m_cycles;
  bit [N_CH-1:0] m_ch;

  task automatic model_defaults();
    m_period = 40000; m_sh_period = 40000;
    for (int k = 0; k < N_CH; k++) begin
      m_start[k] = 0; m_stop[k] = 0; m_sh_start[k] = 0; m_sh_stop[k] = 0;
    end
    m_run = 0; m_cs = 0; m_en_prev = 0; m_pos = 0; m_cycles = 0; m_ch = '0;
  endtask

  task automatic model_step();
    int old_start[N_CH];
    int old_stop[N_CH];
    int old_period;
    int a;
    old_start = m_sh_start; old_stop = m_sh_stop; old_period = m_sh_period;
    for (int k = 0; k < N_CH; k++)
      m_ch[k] = m_run && (m_pos >= m_start[k]) && (m_pos < m_stop[k]);
    if (wr_en) begin
      a = int'(wr_addr);
      if (a < 2 * N_CH) begin
        if (a % 2 == 0) m_sh_start[a / 2] = int'(wr_data);
        else            m_sh_stop[a / 2]  = int'(wr_data);
      end else if (a == 2 * N_CH) begin
        m_sh_period = (int'(wr_data) < 2) ? 2 : int'(wr_data);
      end
    end
    m_cs = 0;
    if (!m_run) begin
      m_start = m_sh_start; m_stop = m_sh_stop; m_period = m_sh_period;
      m_pos = 0;
      if (enable && !m_en_prev) begin
        m_run = 1; m_cs = 1;
      end
    end else if (m_pos == m_period - 1) begin
      m_cycles = (m_cycles + 1) % 65536;
      m_pos = 0;
      if (enable && !oneshot) begin
        m_start = old_start; m_stop = old_stop; m_period = old_period;
        m_cs = 1;
      end else begin
        m_run = 0;
      end
    end else begin
      m_pos++;
    end
    m_en_prev = enable;
  endtask

  always @(posedge clk_2M5 or negedge reset) begin
    if (!reset) model_defaults();
    else        model_step();
  end

  always @(negedge clk_2M5) begin
    if (chk_on) begin
      checks++;
      if (count !== WIDTH'(m_pos) || busy !== m_run || cycle_start !== m_cs ||
          ch_out !== m_ch || cycle_cnt !== WIDTH'(m_cycles)) begin
        errors++;
        $display("FAIL model t=%0t: got cnt=%0d busy=%0b cs=%0b ch=%b ccnt=%0d, expected cnt=%0d busy=%0b cs=%0b ch=%b ccnt=%0d",
                 $time, count, busy, cycle_start, ch_out, cycle_cnt, m_pos, m_run, m_cs, m_ch, m_cycles);
      end
    end
  end

  task automatic tick();
    @(negedge clk_2M5);
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = WIDTH'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_cs(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (cycle_start) return;
      tick();
    end
    checks++; errors++;
    $display("FAIL wait_cs: got no cycle_start within %0d clocks", budget);
  endtask

  // Called at the clock showing cycle_start; returns cycle length and ch0 window
  task automatic measure(input int budget, input int w0_at, input int w0_a, input int w0_d,
                         input int w1_at, input int w1_a, input int w1_d,
                         output int len, output int first, output int last);
    int prev;
    len = 0; first = -1; last = -1;
    for (int i = 0; i < budget; i++) begin
      prev = int'(count);
      wr_en = 1'b0;
      if (prev == w0_at) begin
        wr_en = 1'b1; wr_addr = AW'(w0_a); wr_data = WIDTH'(w0_d);
      end else if (prev == w1_at) begin
        wr_en = 1'b1; wr_addr = AW'(w1_a); wr_data = WIDTH'(w1_d);
      end
      tick();
      wr_en = 1'b0;
      len++;
      if (ch_out[0]) begin
        if (first < 0) first = prev;
        last = prev;
      end
      if (cycle_start || !busy) return;
    end
    checks++; errors++;
    $display("FAIL measure: got no cycle end within %0d clocks", budget);
  endtask

  typedef struct {
    int period; int start; int stop; int junk_addr;
    int exp_len; int exp_first; int exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int len, first, last, prev, n_cs, n_c0, n_c1, n_busy, n_ch, a;

    vecs[0] = '{100, 10,    20,  9, 100, 10, 19};
    vecs[1] = '{100, 25,    25, 63, 100, -1, -1};
    vecs[2] = '{100, 60, 65535,  9, 100, 60, 99};
    vecs[3] = '{  0,  0,     1, 10,   2,  0,  0};
    vecs[4] = '{  1,  0,     5,  9,   2,  0,  1};
    vecs[5] = '{ 50, 40,    10, 33,  50, -1, -1};
    vecs[6] = '{ 20,  0,    20,  9,  20,  0, 19};

    // reset state
    repeat (2) tick();
    check("reset count", int'(count), 0);
    check("reset busy", int'(busy), 0);
    check("reset ch_out", int'(ch_out), 0);
    check("reset cycle_start", int'(cycle_start), 0);
    check("reset cycle_cnt", int'(cycle_cnt), 0);
    #2 reset = 1'b1;
    tick();
    chk_on = 1'b1;

    // continuous run, period 100, two channels
    wr(PADDR, 100); wr(0, 10); wr(1, 20); wr(2, 15); wr(3, 50);
    oneshot = 1'b0; enable = 1'b1;
    n_cs = 0; n_c0 = 0; n_c1 = 0;
    for (int i = 0; i < 301; i++) begin
      tick();
      n_cs += int'(cycle_start); n_c0 += int'(ch_out[0]); n_c1 += int'(ch_out[1]);
    end
    check("main cycle_cnt", int'(cycle_cnt), 3);
    check("main cycle_start pulses", n_cs, 4);
    check("main ch0 high clocks", n_c0, 30);
    check("main ch1 high clocks", n_c1, 105);

    // write during RUN at count 5/6: current cycle unchanged, next cycle uses it
    measure(150, 5, 0, 30, 6, 1, 40, len, first, last);
    check("wr5 cur len", len, 100);
    check("wr5 cur first", first, 10);
    check("wr5 cur last", last, 19);
    measure(150, -1, 0, 0, -1, 0, 0, len, first, last);
    check("wr5 next first", first, 30);
    check("wr5 next last", last, 39);
    // write at count 99 collides with commit: deferred one more cycle
    measure(150, 99, 0, 35, -1, 0, 0, len, first, last);
    check("wr99 cur first", first, 30);
    measure(150, -1, 0, 0, -1, 0, 0, len, first, last);
    check("wr99 next first", first, 30);
    measure(150, -1, 0, 0, -1, 0, 0, len, first, last);
    check("wr99 after first", first, 35);
    check("wr99 after last", last, 39);

    // drop enable at count 40: cycle completes then idle
    prev = 0;
    for (int i = 0; i < 200; i++) begin
      prev = int'(count);
      if (count == 40) enable = 1'b0;
      tick();
      if (!busy) break;
    end
    check("drop last count", prev, 99);
    n_cs = 0;
    repeat (150) begin tick(); n_cs += int'(cycle_start); end
    check("drop no cycle_start", n_cs, 0);
    check("drop busy", int'(busy), 0);

    // oneshot: one cycle per enable rise
    #2 reset = 1'b0;
    tick();
    #2 reset = 1'b1;
    tick();
    wr(PADDR, 100); wr(0, 10); wr(1, 20);
    oneshot = 1'b1; enable = 1'b1;
    wait_cs(10);
    measure(150, -1, 0, 0, -1, 0, 0, len, first, last);
    check("os1 len", len, 100);
    check("os1 first", first, 10);
    check("os1 last", last, 19);
    n_cs = 0; n_busy = 0; n_ch = 0;
    repeat (150) begin
      tick();
      n_cs += int'(cycle_start); n_busy += int'(busy); n_ch += int'(ch_out != '0);
    end
    check("os hold cycle_start", n_cs, 0);
    check("os hold busy", n_busy, 0);
    check("os hold ch_out", n_ch, 0);
    enable = 1'b0; tick(); enable = 1'b1;
    wait_cs(10);
    measure(150, -1, 0, 0, -1, 0, 0, len, first, last);
    check("os2 len", len, 100);
    check("os2 cycle_cnt", int'(cycle_cnt), 2);
    enable = 1'b0; tick();

    // table of single-cycle edge cases on ch0
    for (int i = 0; i < 7; i++) begin
      wr(PADDR, vecs[i].period); wr(0, vecs[i].start); wr(1, vecs[i].stop);
      wr(vecs[i].junk_addr, 3);
      enable = 1'b1;
      wait_cs(10);
      measure(200, -1, 0, 0, -1, 0, 0, len, first, last);
      check($sformatf("vec%0d len", i), len, vecs[i].exp_len);
      check($sformatf("vec%0d first", i), first, vecs[i].exp_first);
      check($sformatf("vec%0d last", i), last, vecs[i].exp_last);
      enable = 1'b0; tick();
    end

    // enable rise and write in the same clock: starting cycle sees the write
    wr(1, 8);
    enable = 1'b1; wr_en = 1'b1; wr_addr = AW'(0); wr_data = WIDTH'(3);
    tick();
    wr_en = 1'b0;
    wait_cs(5);
    measure(100, -1, 0, 0, -1, 0, 0, len, first, last);
    check("same-clk len", len, 20);
    check("same-clk first", first, 3);
    check("same-clk last", last, 7);
    enable = 1'b0; tick();

    // randomized traffic against the model
    wr(PADDR, 12);
    for (int i = 0; i < 3000; i++) begin
      wr_en = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        a = int'($urandom_range(0, 11));
        wr_en = 1'b1; wr_addr = AW'(a);
        wr_data = (a == PADDR) ? WIDTH'($urandom_range(0, 30)) : WIDTH'($urandom_range(0, 34));
      end
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      if ($urandom_range(0, 59) == 0) oneshot = ~oneshot;
      tick();
    end
    wr_en = 1'b0; enable = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    check("random drains to idle", int'(busy), 0);

    // async reset mid-RUN, then defaults restored
    wr(PADDR, 100); wr(0, 50); wr(1, 60);
    oneshot = 1'b0; enable = 1'b1;
    wait_cs(10);
    for (int i = 0; i < 200; i++) begin
      if (count == 57) break;
      tick();
    end
    check("pre-reset ch0", int'(ch_out[0]), 1);
    #2 reset = 1'b0;
    #1;
    check("midrst count", int'(count), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst ch_out", int'(ch_out), 0);
    check("midrst cycle_start", int'(cycle_start), 0);
    check("midrst cycle_cnt", int'(cycle_cnt), 0);
    enable = 1'b0; oneshot = 1'b1;
    tick();
    #2 reset = 1'b1;
    tick();
    enable = 1'b1;
    wait_cs(5);
    measure(40100, -1, 0, 0, -1, 0, 0, len, first, last);
    check("default period len", len, 40000);
    check("default ch0 never", first, -1);
    enable = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
